// File: rtl/conv_arith_pkg.sv
// Shared types and constants for the conv datapath adder tree and its scheduler.
package conv_arith_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_e;

    localparam int TREE_LANES = 16;
    localparam int TREE_LAT   = 4;

    function automatic int tree_sum_w(input int data_w);
        return data_w + 4;
    endfunction

endpackage

// File: rtl/add_tree16_pipe.sv
// 16-lane, 4-stage registered balanced adder tree; every stage advances together on ien.
module add_tree16_pipe
    import conv_arith_pkg::*;
#(
    parameter int pDATA_W = 8
) (
    input  logic                                iclk,
    input  logic                                irst,
    input  logic                                ien,
    input  logic [TREE_LANES*pDATA_W-1:0]       idata,
    output logic [tree_sum_w(pDATA_W)-1:0]      osum
);

    // Bit offset of stage s inside the flat node vector; stage s nodes are pDATA_W+s+1 wide.
    function automatic int stage_off(input int s);
        int o;
        o = 0;
        for (int t = 0; t < s; t++) o += (TREE_LANES >> (t + 1)) * (pDATA_W + t + 1);
        return o;
    endfunction

    localparam int TOT = stage_off(TREE_LAT);
    localparam int SW  = tree_sum_w(pDATA_W);

    logic [TOT-1:0] tq, tn;

    for (genvar s = 0; s < TREE_LAT; s++) begin : g_st
        localparam int N    = TREE_LANES >> (s + 1);
        localparam int W    = pDATA_W + s + 1;
        localparam int OFF  = stage_off(s);
        localparam int POFF = (s == 0) ? 0 : stage_off(s - 1);
        for (genvar j = 0; j < N; j++) begin : g_nd
            if (s == 0) begin : g_leaf
                assign tn[OFF + j*W +: W] = W'(idata[(2*j)*pDATA_W +: pDATA_W])
                                          + W'(idata[(2*j+1)*pDATA_W +: pDATA_W]);
            end else begin : g_int
                assign tn[OFF + j*W +: W] = W'(tq[POFF + (2*j)*(W-1) +: W-1])
                                          + W'(tq[POFF + (2*j+1)*(W-1) +: W-1]);
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (irst)     tq <= '0;
        else if (ien) tq <= tn;
    end

    assign osum = tq[TOT-1 -: SW];

endmodule

// File: rtl/add_tree_acc_sched.sv
// Burst scheduler/accumulator around the 16-input adder tree.
// Build option ADD_TREE_ACC_SAT_EN: saturating accumulator plus sticky osat output.
module add_tree_acc_sched
    import conv_arith_pkg::*;
#(
    parameter int pDATA_W   = 8,
    parameter int pLANES    = 16,
    parameter int pTREE_LAT = 4,
    parameter int pLEN_W    = 8,
    parameter int pACC_W    = 24
) (
    input  logic                        iclk,
    input  logic                        irst,
    input  logic                        istart,
    input  logic [pLEN_W-1:0]           icfg_len,
    input  logic                        ivalid,
    output logic                        oready,
    input  logic [pLANES*pDATA_W-1:0]   idata,
    output logic                        ovalid,
    input  logic                        iready,
    output logic [pACC_W-1:0]           odata,
    output logic                        obusy
`ifdef ADD_TREE_ACC_SAT_EN
    ,
    output logic                        osat
`endif
);

    localparam int SW = tree_sum_w(pDATA_W);

    state_e               state, state_nxt;
    logic [pLEN_W-1:0]    len, cnt_in, cnt_out;
    logic [pACC_W-1:0]    acc, acc_nxt, odata_q;
    logic [pTREE_LAT-1:0] vld_pipe;
    logic [SW-1:0]        tree_sum;
    logic                 fire, tree_en, last_in, sum_vld, ovalid_q;

    assign oready  = (state == RUN);
    assign fire    = ivalid & oready;
    assign tree_en = (state == RUN) || (state == DRAIN);
    assign last_in = fire && (cnt_in == len - 1'b1);
    assign sum_vld = tree_en && vld_pipe[pTREE_LAT-1];

    add_tree16_pipe #(.pDATA_W(pDATA_W)) u_tree (
        .iclk  (iclk),
        .irst  (irst),
        .ien   (tree_en),
        .idata (idata),
        .osum  (tree_sum)
    );

`ifdef ADD_TREE_ACC_SAT_EN
    logic [pACC_W:0] acc_sum;
    logic            sat;
    assign acc_sum = {1'b0, acc} + (pACC_W+1)'(tree_sum);
    assign acc_nxt = acc_sum[pACC_W] ? '1 : acc_sum[pACC_W-1:0];
    assign osat    = sat;

    always_ff @(posedge iclk) begin
        if (irst)                      sat <= 1'b0;
        else if (state == IDLE && istart) sat <= 1'b0;
        else if (sum_vld && acc_sum[pACC_W]) sat <= 1'b1;
    end
`else
    assign acc_nxt = acc + pACC_W'(tree_sum);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (istart) state_nxt = (icfg_len != '0) ? RUN : OUT;
            RUN:     if (last_in) state_nxt = DRAIN;
            DRAIN:   if (cnt_out == len) state_nxt = OUT;
            OUT:     if (ovalid_q && iready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state    <= IDLE;
            len      <= '0;
            cnt_in   <= '0;
            cnt_out  <= '0;
            acc      <= '0;
            vld_pipe <= '0;
            ovalid_q <= 1'b0;
            odata_q  <= '0;
        end else begin
            state <= state_nxt;
            if (tree_en) vld_pipe <= {vld_pipe[pTREE_LAT-2:0], fire};
            if (state == IDLE && istart) begin
                len     <= icfg_len;
                acc     <= '0;
                cnt_in  <= '0;
                cnt_out <= '0;
                // Empty burst goes straight to OUT with a zero result.
                if (icfg_len == '0) begin
                    odata_q  <= '0;
                    ovalid_q <= 1'b1;
                end
            end
            if (fire) cnt_in <= cnt_in + 1'b1;
            if (sum_vld) begin
                acc     <= acc_nxt;
                cnt_out <= cnt_out + 1'b1;
            end
            if (state == DRAIN && cnt_out == len) begin
                odata_q  <= acc;
                ovalid_q <= 1'b1;
            end
            if (state == OUT && ovalid_q && iready) ovalid_q <= 1'b0;
        end
    end

    assign ovalid = ovalid_q;
    assign odata  = odata_q;
    assign obusy  = (state != IDLE);

endmodule
